// File: rtl/seg7_pkg.sv
// Shared types, glyph codes and message ROM for the 7-segment message sequencer.
package seg7_pkg;

  localparam int unsigned GLYPH_W    = 6;
  localparam int unsigned MSG_SLOTS  = 8;
  localparam int unsigned MSG_COUNT  = 4;
  localparam int unsigned SLOT_W     = $clog2(MSG_SLOTS);
  localparam int unsigned SLOT_IDX_W = SLOT_W + 1;

  typedef logic [GLYPH_W-1:0] glyph_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_GAP,
    ST_PAUSED
  } seq_state_e;

  localparam glyph_t G_BLANK = 6'd63;
  localparam glyph_t G_A     = 6'd16;
  localparam glyph_t G_E     = 6'd21;
  localparam glyph_t G_F     = 6'd22;
  localparam glyph_t G_H_LO  = 6'd25;
  localparam glyph_t G_I     = 6'd27;
  localparam glyph_t G_L     = 6'd29;
  localparam glyph_t G_O     = 6'd31;
  localparam glyph_t G_P     = 6'd33;
  localparam glyph_t G_S     = 6'd36;

  // Messages are terminated by the first blank slot or by the last slot.
  localparam glyph_t MSG_ROM [MSG_COUNT][MSG_SLOTS] = '{
    '{G_H_LO, G_E, G_L, G_L, G_O, G_BLANK, G_BLANK, G_BLANK},
    '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7},
    '{G_P, G_A, G_S, G_S, G_BLANK, G_BLANK, G_BLANK, G_BLANK},
    '{G_F, G_A, G_I, G_L, G_BLANK, G_BLANK, G_BLANK, G_BLANK}
  };

  function automatic glyph_t rom_glyph(input logic [1:0] sel,
                                       input logic [SLOT_IDX_W-1:0] slot);
    if (slot >= SLOT_IDX_W'(MSG_SLOTS)) return G_BLANK;
    return MSG_ROM[sel][slot[SLOT_W-1:0]];
  endfunction

endpackage

// File: rtl/seg7_glyph_decoder.sv
// Glyph code to 7-segment pattern, bit order g..a, 1 = segment lit.
module seg7_glyph_decoder
  import seg7_pkg::*;
(
  input  glyph_t     code,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h00;
    case (code)
      6'd0:  seg_c = 7'h3F;
      6'd1:  seg_c = 7'h06;
      6'd2:  seg_c = 7'h5B;
      6'd3:  seg_c = 7'h4F;
      6'd4:  seg_c = 7'h66;
      6'd5:  seg_c = 7'h6D;
      6'd6:  seg_c = 7'h7D;
      6'd7:  seg_c = 7'h07;
      6'd8:  seg_c = 7'h7F;
      6'd9:  seg_c = 7'h6F;
      6'd10: seg_c = 7'h77;
      6'd11: seg_c = 7'h7C;
      6'd12: seg_c = 7'h39;
      6'd13: seg_c = 7'h5E;
      6'd14: seg_c = 7'h79;
      6'd15: seg_c = 7'h71;
      // Letters and symbols: A b C c d E F G H h i I J L n O o P q r S t U u y -
      6'd16: seg_c = 7'h77;
      6'd17: seg_c = 7'h7C;
      6'd18: seg_c = 7'h39;
      6'd19: seg_c = 7'h58;
      6'd20: seg_c = 7'h5E;
      6'd21: seg_c = 7'h79;
      6'd22: seg_c = 7'h71;
      6'd23: seg_c = 7'h3D;
      6'd24: seg_c = 7'h76;
      6'd25: seg_c = 7'h74;
      6'd26: seg_c = 7'h04;
      6'd27: seg_c = 7'h30;
      6'd28: seg_c = 7'h1E;
      6'd29: seg_c = 7'h38;
      6'd30: seg_c = 7'h54;
      6'd31: seg_c = 7'h3F;
      6'd32: seg_c = 7'h5C;
      6'd33: seg_c = 7'h73;
      6'd34: seg_c = 7'h67;
      6'd35: seg_c = 7'h50;
      6'd36: seg_c = 7'h6D;
      6'd37: seg_c = 7'h78;
      6'd38: seg_c = 7'h3E;
      6'd39: seg_c = 7'h1C;
      6'd40: seg_c = 7'h6E;
      6'd41: seg_c = 7'h40;
      default: seg_c = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg7_msg_sequencer.sv
// Plays a stored message one glyph at a time with hold/blank timing, pause and single-step.
module seg7_msg_sequencer
  import seg7_pkg::*;
#(
  parameter int unsigned MSG_LEN     = MSG_SLOTS,
  parameter int unsigned HOLD_TICKS  = 4,
  parameter int unsigned BLANK_TICKS = 1
) (
  input  logic                       clk_2,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       step,
  input  logic [1:0]                 msg_sel,
  output logic [7:0]                 SEG,
  output logic [GLYPH_W-1:0]         code,
  output logic [$clog2(MSG_LEN)-1:0] index,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned IW      = $clog2(MSG_LEN);
  localparam int unsigned CNT_MAX = (HOLD_TICKS > BLANK_TICKS) ? HOLD_TICKS : BLANK_TICKS;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] HOLD_FULL  = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_TICKS > 0) ? CW'(BLANK_TICKS - 1) : '0;
  localparam logic [CW-1:0] BLANK_FULL = CW'(BLANK_TICKS);

  seq_state_e      state_q, state_d;
  seq_state_e      ret_q, ret_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   index_q, index_d;
  glyph_t          code_q, code_d;
  logic [1:0]      sel_q, sel_d;
  logic            done_q, done_d;
  logic            busy_q, dp_q;
  logic            step_q;

  logic            step_rise_c;
  logic [IW:0]     next_slot_c;
  logic            last_c;
  glyph_t          next_glyph_c;
  glyph_t          first_glyph_c;
  logic            do_expire_c;
  logic            do_adv_c;
  logic            adv_paused_c;
  logic [6:0]      seg_c;

  seg7_glyph_decoder u_decoder (
    .code  (code_q),
    .seg_c (seg_c)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_SHOW;
      cnt_q   <= '0;
      index_q <= '0;
      code_q  <= G_BLANK;
      sel_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dp_q    <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      index_q <= index_d;
      code_q  <= code_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
      dp_q    <= (state_d == ST_PAUSED);
      step_q  <= step;
    end
  end

  // Next-state logic; a pause entry counts its own cycle so resume continues the remaining count.
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    cnt_d         = cnt_q;
    index_d       = index_q;
    code_d        = code_q;
    sel_d         = sel_q;
    done_d        = 1'b0;
    do_expire_c   = 1'b0;
    do_adv_c      = 1'b0;
    adv_paused_c  = 1'b0;
    step_rise_c   = step & ~step_q;
    next_slot_c   = {1'b0, index_q} + (IW + 1)'(1);
    next_glyph_c  = rom_glyph(sel_q, SLOT_IDX_W'(next_slot_c));
    first_glyph_c = rom_glyph(msg_sel, '0);
    last_c        = (index_q == IW'(MSG_LEN - 1)) || (next_glyph_c == G_BLANK);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d   = msg_sel;
          index_d = '0;
          cnt_d   = '0;
          if (first_glyph_c == G_BLANK) begin
            done_d = 1'b1;
            code_d = G_BLANK;
          end else begin
            code_d  = first_glyph_c;
            state_d = ST_SHOW;
          end
        end
      end
      ST_SHOW: begin
        if (pause) begin
          state_d = ST_PAUSED;
          ret_d   = ST_SHOW;
          cnt_d   = cnt_q + CW'(1);
        end else if (cnt_q >= HOLD_LAST) begin
          do_expire_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (pause) begin
          state_d = ST_PAUSED;
          ret_d   = ST_GAP;
          cnt_d   = cnt_q + CW'(1);
        end else if (cnt_q >= BLANK_LAST) begin
          do_adv_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PAUSED: begin
        if (!pause) begin
          if (ret_q == ST_SHOW && cnt_q >= HOLD_FULL) begin
            do_expire_c = 1'b1;
          end else if (ret_q == ST_GAP && cnt_q >= BLANK_FULL) begin
            do_adv_c = 1'b1;
          end else begin
            state_d = ret_q;
          end
        end else if (step_rise_c) begin
          do_adv_c     = 1'b1;
          adv_paused_c = 1'b1;
        end
      end
    endcase

    if (do_expire_c) begin
      if (BLANK_TICKS > 0) begin
        state_d = ST_GAP;
        code_d  = G_BLANK;
        cnt_d   = '0;
      end else begin
        do_adv_c = 1'b1;
      end
    end

    // A stepped advance stays paused at the start of the next glyph.
    if (do_adv_c) begin
      cnt_d = '0;
      if (last_c) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        code_d  = G_BLANK;
        index_d = '0;
      end else begin
        index_d = next_slot_c[IW-1:0];
        code_d  = next_glyph_c;
        ret_d   = ST_SHOW;
        state_d = adv_paused_c ? ST_PAUSED : ST_SHOW;
      end
    end
  end

  assign SEG   = {dp_q, seg_c};
  assign code  = code_q;
  assign index = index_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seg7_msg_sequencer.sv
// Directed self-checking bench for seg7_msg_sequencer (gap and no-gap configurations).
module tb_seg7_msg_sequencer;

  logic       clk_2;
  logic       reset_n;
  logic       start, start_b, pause, step;
  logic [1:0] msg_sel;
  logic [7:0] seg_a, seg_b;
  logic [5:0] code_a, code_b;
  logic [2:0] index_a, index_b;
  logic       busy_a, busy_b, done_a, done_b;

  int checks   = 0;
  int failures = 0;

  int t2_exp [20] = '{22,22,22,22,63, 16,16,16,16,63, 27,27,27,27,63, 29,29,29,29,63};
  int t3_exp [6]  = '{33,33,33,33,63,16};
  int t5_gly [5]  = '{25,21,29,29,31};

  seg7_msg_sequencer #(.MSG_LEN(8), .HOLD_TICKS(4), .BLANK_TICKS(1)) dut_a (
    .clk_2(clk_2), .reset_n(reset_n), .start(start), .pause(pause), .step(step),
    .msg_sel(msg_sel), .SEG(seg_a), .code(code_a), .index(index_a),
    .busy(busy_a), .done(done_a)
  );

  seg7_msg_sequencer #(.MSG_LEN(8), .HOLD_TICKS(4), .BLANK_TICKS(0)) dut_b (
    .clk_2(clk_2), .reset_n(reset_n), .start(start_b), .pause(pause), .step(step),
    .msg_sel(msg_sel), .SEG(seg_b), .code(code_b), .index(index_b),
    .busy(busy_b), .done(done_b)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; start_b = 1'b0; pause = 1'b0; step = 1'b0; msg_sel = 2'd0;
    tick(); tick();
    chk("reset_code", 32'(code_a), 63);
    chk("reset_seg", 32'(seg_a), 0);
    chk("reset_busy", 32'(busy_a), 0);
    chk("reset_done", 32'(done_a), 0);
    chk("reset_index", 32'(index_a), 0);
    reset_n = 1'b1;
    tick();

    // 1: asynchronous reset in the middle of playback
    msg_sel = 2'd1; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("t1_busy_before", 32'(busy_a), 1);
    #3 reset_n = 1'b0;
    #1;
    chk("t1_seg", 32'(seg_a), 0);
    chk("t1_code", 32'(code_a), 63);
    chk("t1_busy", 32'(busy_a), 0);
    reset_n = 1'b1;
    tick(); tick();
    chk("t1_idle_code", 32'(code_a), 63);
    chk("t1_idle_busy", 32'(busy_a), 0);

    // 2: "FAIL" with hold 4, blank 1
    msg_sel = 2'd3; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("t2_code", 32'(code_a), t2_exp[i]);
      chk("t2_index", 32'(index_a), i / 5);
      chk("t2_busy", 32'(busy_a), 1);
      if (i == 0) chk("t2_seg_F", 32'(seg_a), 32'h71);
      if (i == 5) chk("t2_seg_A", 32'(seg_a), 32'h77);
      tick();
    end
    chk("t2_done", 32'(done_a), 1);
    chk("t2_done_busy", 32'(busy_a), 0);
    chk("t2_done_code", 32'(code_a), 63);
    tick();
    chk("t2_done_pulse", 32'(done_a), 0);

    // 3: "PASS" paused on the second cycle of A
    msg_sel = 2'd2; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t3_code", 32'(code_a), t3_exp[i]);
      tick();
    end
    chk("t3_code_A2", 32'(code_a), 16);
    pause = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      chk("t3_pause_code", 32'(code_a), 16);
      chk("t3_pause_seg", 32'(seg_a), 32'hF7);
      chk("t3_pause_busy", 32'(busy_a), 1);
      if (i == 3) pause = 1'b0;
      tick();
    end
    chk("t3_resume1_seg", 32'(seg_a), 32'h77);
    tick();
    chk("t3_resume2_code", 32'(code_a), 16);
    tick();
    chk("t3_gap_code", 32'(code_a), 63);
    tick();
    chk("t3_S_code", 32'(code_a), 36);
    chk("t3_S_index", 32'(index_a), 2);
    repeat (10) tick();
    chk("t3_done", 32'(done_a), 1);
    chk("t3_done_busy", 32'(busy_a), 0);
    tick();

    // 4: single-step while paused, step held high advances once
    msg_sel = 2'd1; start = 1'b1; tick(); start = 1'b0;
    chk("t4_code0", 32'(code_a), 0);
    pause = 1'b1; tick();
    chk("t4_paused_seg", 32'(seg_a), 32'hBF);
    chk("t4_paused_index", 32'(index_a), 0);
    step = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      chk("t4_step_code", 32'(code_a), 1);
      chk("t4_step_index", 32'(index_a), 1);
      if (i == 3) step = 1'b0;
      tick();
    end
    chk("t4_held_code", 32'(code_a), 1);
    step = 1'b1; tick();
    chk("t4_step2_code", 32'(code_a), 2);
    chk("t4_step2_index", 32'(index_a), 2);
    step = 1'b0; tick();
    chk("t4_step2_seg", 32'(seg_a), 32'hDB);
    pause = 1'b0; tick();
    chk("t4_resume_seg", 32'(seg_a), 32'h5B);
    repeat (3) tick();
    chk("t4_hold_last", 32'(code_a), 2);
    tick();
    chk("t4_gap", 32'(code_a), 63);
    tick();
    chk("t4_next_code", 32'(code_a), 3);
    chk("t4_next_index", 32'(index_a), 3);
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    chk("t4_abort_busy", 32'(busy_a), 0);

    // 5: start/msg_sel changes while busy are ignored; "hELLO" ends at slot 5
    msg_sel = 2'd0; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      chk("t5_code", 32'(code_a), (i % 5 == 4) ? 63 : t5_gly[i / 5]);
      if (i == 2) begin msg_sel = 2'd2; start = 1'b1; end
      if (i == 10) start = 1'b0;
      tick();
    end
    chk("t5_done", 32'(done_a), 1);
    chk("t5_done_busy", 32'(busy_a), 0);
    tick();
    chk("t5_stay_idle", 32'(busy_a), 0);

    // 6: no blank gap, "01234567" runs all eight slots; start held restarts after done
    msg_sel = 2'd1; start_b = 1'b1; tick(); start_b = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("t6_code", 32'(code_b), i / 4);
      chk("t6_index", 32'(index_b), i / 4);
      tick();
    end
    chk("t6_done", 32'(done_b), 1);
    chk("t6_done_code", 32'(code_b), 63);
    chk("t6_done_busy", 32'(busy_b), 0);
    start_b = 1'b1; tick(); start_b = 1'b0;
    chk("t6_restart_code", 32'(code_b), 0);
    chk("t6_restart_busy", 32'(busy_b), 1);
    chk("t6_a_idle", 32'(busy_a), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
